pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational lookahead adder.
- Splits a WIDTH-bit operation into WIDTH/BLK slices, one slice per pipeline stage. The inter-slice carry is registered between stages.
- Valid/ready streaming interface. Accepts one operation per cycle, stalls under backpressure, and adds subtract mode plus status flags.
- Sits between operand sources (register file / ALU operand latches) and the result writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLK.
- BLK, 16, bits resolved per pipeline stage; must be a multiple of 4.
- NSTG, WIDTH/BLK, derived (localparam), number of pipeline stages = latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operation present on a/b/cin/sub.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in in subtract mode).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present on f/cout/ovf/zero.
- out_ready  input  1  downstream accepts result this cycle.
- f  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  f == 0.

Behaviour:
- Arithmetic:
  - Effective B: bx = sub ? ~b : b. Effective carry-in: c0 = cin ^ sub.
  - f = (a + bx + c0) mod 2^WIDTH.
  - cout = carry out of MSB. In subtract mode cout = 1 means no borrow.
  - ovf = carry into MSB XOR cout.
  - Subtract with cin=0 gives a−b; with cin=1 gives a−b−1.
- Slice logic:
  - Stage k resolves bits [k*BLK +: BLK] with 4-bit CLA groups (bit g/p) and a second-level group lookahead across groups.
  - No ripple across groups inside a stage.
  - Carry out of stage k is registered and used as carry-in of stage k+1.
- Skew/deskew:
  - Operand slices for stage k are delayed k cycles so they meet their registered carry.
  - Completed low result slices are delayed so all slices of one operation emerge together.
  - ovf, cout and zero are computed in the last stage.
- Flow control:
  - Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational.
  - On adv, every stage register, including its valid bit, shifts one stage. When adv = 0, all stages hold.
  - Bubbles are not collapsed.
  - Accept occurs when in_valid & in_ready. When in_valid = 0 during adv, a bubble (valid = 0) enters.
- Latency and throughput:
  - A result accepted at cycle t appears with out_valid = 1 at cycle t+NSTG, provided no stall occurs in between.
  - Each stall cycle adds one cycle.
  - Throughput is 1 operation/cycle when out_ready is held high.
- Ordering: results leave in acceptance order; none dropped, none duplicated.
- Output hold: while out_valid = 1 and out_ready = 0, f/cout/ovf/zero hold stable.
- Reset:
  - rst = 1 clears all stage valid bits, all data and carry registers, and f, cout, ovf, zero, out_valid to 0 on the next edge.
  - In-flight operations are discarded.
  - in_ready = 1 in the first cycle after reset.
  - rst takes priority over acceptance in the same cycle.
- Simultaneous events: out_valid & out_ready together with in_valid in the same cycle accepts and retires in one cycle with no bubble.
- Parameter legality: WIDTH % BLK != 0 or BLK % 4 != 0 is an elaboration error (generate-time check).

Test Plan:
- Simple add, default params: a=0x11111111, b=0x11111111, cin=0, sub=0, out_ready=1 -> 2 cycles later f=0x22222222, cout=0, ovf=0, zero=0.
- Cross-stage carry: a=0xFFFFFFFF, b=0x00000001, add -> f=0x00000000, cout=1, zero=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 -> f=0x80000000, ovf=1, cout=0.
- Subtract with borrow-in:
  - a=5, b=7, sub=1, cin=0 -> f=0xFFFFFFFE, cout=0, ovf=0.
  - a=7, b=5, sub=1, cin=1 -> f=0x00000001, cout=1.
- Backpressure: stream 6 back-to-back ops and drop out_ready for 3 cycles mid-stream -> in_ready=0 during stall, outputs held stable, all 6 results in order, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst 1 cycle -> out_valid=0 next cycle and stays 0 until new accepts; no stale result emerges.
- Alternate config WIDTH=16, BLK=4 (latency 4): a=0xFFFF, b=0xFFFF, cin=1, add -> f=0xFFFF, cout=1, ovf=0, out_valid exactly 4 cycles after accept.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one BLK-bit slice per stage
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTG = WIDTH / BLK;
    localparam int NG   = BLK / 4;

    typedef struct packed {
        logic [BLK-1:0] s;
        logic           co;
    } slice_t;

    // Two-level lookahead: 4-bit group g/p, then every group carry as a flat sum of products.
    function automatic slice_t slice_add(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                         input logic ci);
        logic [BLK-1:0] g, p, c;
        logic [NG-1:0]  gg, gp;
        logic [NG:0]    gc;
        logic           t;
        slice_t         res;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | ((&p[4*j+3 -: 2]) & g[4*j+1])
                  | ((&p[4*j+3 -: 3]) & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        for (int j = 0; j <= NG; j++) begin
            t = ci;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        res.s  = p ^ c;
        res.co = gc[NG];
        return res;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign bx       = sub ? ~b : b;
    assign c0       = cin ^ sub;

    generate
        if ((WIDTH % BLK) != 0 || (BLK % 4) != 0) begin : g_bad_params
            $error("pipelined_cla_adder: WIDTH must be a multiple of BLK and BLK a multiple of 4");
        end

        for (genvar k = 0; k < NSTG; k++) begin : g_stg
            localparam int IW = WIDTH - k * BLK;
            // Operands not yet consumed travel with the op, so slice k meets its registered carry.
            logic [IW-1:0]        in_a, in_b;
            logic                 in_c, in_v;
            slice_t               r;
            logic [(k+1)*BLK-1:0] f_next, f_r;
            logic                 v_r, c_r;

            assign r = slice_add(in_a[BLK-1:0], in_b[BLK-1:0], in_c);

            if (k == 0) begin : g_src
                assign in_a   = a;
                assign in_b   = bx;
                assign in_c   = c0;
                assign in_v   = in_valid;
                assign f_next = r.s;
            end else begin : g_src
                assign in_a   = g_stg[k-1].g_ops.a_r;
                assign in_b   = g_stg[k-1].g_ops.b_r;
                assign in_c   = g_stg[k-1].c_r;
                assign in_v   = g_stg[k-1].v_r;
                assign f_next = {r.s, g_stg[k-1].f_r};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    c_r <= 1'b0;
                    f_r <= '0;
                end else if (adv) begin
                    v_r <= in_v;
                    c_r <= r.co;
                    f_r <= f_next;
                end
            end

            if (IW > BLK) begin : g_ops
                logic [IW-BLK-1:0] a_r, b_r;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_r <= '0;
                        b_r <= '0;
                    end else if (adv) begin
                        a_r <= in_a[IW-1:BLK];
                        b_r <= in_b[IW-1:BLK];
                    end
                end
            end

            if (k == NSTG - 1) begin : g_last
                logic ovf_r, zero_r;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_r  <= 1'b0;
                        zero_r <= 1'b0;
                    end else if (adv) begin
                        // Carry into the MSB is recovered from the MSB sum bit.
                        ovf_r  <= (in_a[BLK-1] ^ in_b[BLK-1] ^ r.s[BLK-1]) ^ r.co;
                        zero_r <= ~|f_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[NSTG-1].v_r;
    assign f         = g_stg[NSTG-1].f_r;
    assign cout      = g_stg[NSTG-1].c_r;
    assign ovf       = g_stg[NSTG-1].g_last.ovf_r;
    assign zero      = g_stg[NSTG-1].g_last.zero_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder (32/16 and 16/4 configs)
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, f;
    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2, zero2;
    logic [15:0] a2, b2, f2;

    pipelined_cla_adder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .f(f),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(16), .BLK(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .f(f2),
        .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    typedef struct {
        logic [31:0] f;
        logic        co, ov, z;
        int          acc;
        int          st;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb);
        logic [32:0] sum;
        logic [31:0] mask, bxv, fv;
        exp_t        e;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bxv   = (sb ? ~bv : bv) & mask;
        sum   = {1'b0, av & mask} + {1'b0, bxv} + {32'd0, ci ^ sb};
        fv    = sum[31:0] & mask;
        e.f   = fv;
        e.co  = sum[w];
        e.ov  = (av[w-1] == bxv[w-1]) && (fv[w-1] != av[w-1]);
        e.z   = (fv == 32'd0);
        e.acc = 0;
        e.st  = 0;
        return e;
    endfunction

    // Monitor: pushes on accept, pops and compares on retire, checks hold under stall.
    initial begin
        logic        held;
        logic [31:0] hf;
        logic        hc, ho, hz;
        exp_t        e;
        held = 1'b0;
        hf = '0; hc = 1'b0; ho = 1'b0; hz = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q1.delete();
                q2.delete();
                held = 1'b0;
            end else begin
                chk("in_ready", in_ready, !out_valid || out_ready);
                if (held) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_f", f, hf);
                    chk("hold_flags", {cout, ovf, zero}, {hc, ho, hz});
                end
                if (q1.size() == 0) chk("idle_out_valid", out_valid, 0);
                if (out_valid && out_ready && q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("f", f, e.f);
                    chk("cout", cout, e.co);
                    chk("ovf", ovf, e.ov);
                    chk("zero", zero, e.z);
                    chk("latency", cyc - e.acc, 2 + stalls - e.st);
                end
                held = out_valid && !out_ready;
                hf = f; hc = cout; ho = ovf; hz = zero;
                if (out_valid && !out_ready) stalls++;
                if (in_valid && in_ready) begin
                    e = model(32, a, b, cin, sub);
                    e.acc = cyc;
                    e.st = stalls;
                    q1.push_back(e);
                end

                if (q2.size() == 0) chk("idle_out_valid2", out_valid2, 0);
                if (out_valid2 && q2.size() != 0) begin
                    e = q2.pop_front();
                    chk("f2", f2, e.f[15:0]);
                    chk("flags2", {cout2, ovf2, zero2}, {e.co, e.ov, e.z});
                    chk("latency2", cyc - e.acc, 4);
                end
                if (in_valid2 && in_ready2) begin
                    e = model(16, {16'd0, a2}, {16'd0, b2}, cin2, sub2);
                    e.acc = cyc;
                    q2.push_back(e);
                end
            end
            cyc++;
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic ts);
        int n;
        n = 0;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic ts);
        in_valid2 = 1'b1; a2 = ta; b2 = tb; cin2 = tc; sub2 = ts;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f", f, 0);
        chk("rst_flags", {cout, ovf, zero}, 3'b000);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid2", out_valid2, 0);
        chk("rst_f2", f2, 0);
        @(posedge clk);
        #1;

        send(32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        idle(4);

        fork
            for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        idle(4);

        done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(2) == 0) idle($urandom_range(2, 1));
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #2 out_ready = ($urandom_range(3) != 0);
            end
        join
        out_ready = 1'b1;
        idle(6);

        send(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1);
        idle(4);

        in_valid2 = 1'b1; a2 = 16'hFFFF; b2 = 16'hFFFF; cin2 = 1'b1; sub2 = 1'b0;
        @(negedge clk);
        chk("w16_in_ready", in_ready2, 1);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid2 && n < 10);
        chk("w16_latency", n, 4);
        chk("w16_f", f2, 16'hFFFF);
        chk("w16_flags", {cout2, ovf2, zero2}, 3'b100);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) send2(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        send2(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send2(16'h8000, 16'h0001, 1'b0, 1'b1);

        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
